// File: rtl/button_debouncer_array.sv
// rtl/button_debouncer_array.sv - multi-channel button debouncer with press/release/long-press strobes
module button_debouncer_array #(
   parameter int CHANNELS      = 4,
   parameter int HOLDOFF       = 500000,
   parameter int CNT_W         = 19,
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 0,
   parameter int LONG_W        = 26,
   parameter int ACTIVE_LOW    = 0,
   parameter int STRETCH_MODE  = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_strobe,
   output logic [CHANNELS-1:0] long_press,
   output logic                busy
);

   localparam logic [CNT_W-1:0]  HOLD_MAX   = CNT_W'(HOLDOFF - 1);
   localparam logic [LONG_W-1:0] LONG_MAX   = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] REPEAT_MAX = LONG_W'(REPEAT_CYCLES - 1);

   logic [CHANNELS-1:0] pin_b;
   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s2;
   logic [CNT_W-1:0]    cnt     [CHANNELS];
   logic [CNT_W-1:0]    cnt_n   [CHANNELS];
   logic [LONG_W-1:0]   hold    [CHANNELS];
   logic [LONG_W-1:0]   hold_n  [CHANNELS];
   logic [CHANNELS-1:0] rpt;
   logic [CHANNELS-1:0] rpt_n;
   logic [CHANNELS-1:0] out_n;
   logic [CHANNELS-1:0] press_n;
   logic [CHANNELS-1:0] rel_n;
   logic [CHANNELS-1:0] long_n;

   assign pin_b = (ACTIVE_LOW != 0) ? ~button : button;

   always_comb begin
      out_n   = out;
      press_n = '0;
      rel_n   = '0;
      long_n  = '0;
      rpt_n   = rpt;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_n[i]  = cnt[i];
         hold_n[i] = hold[i];
         if (STRETCH_MODE == 0) begin
            if (s2[i] == out[i]) begin
               cnt_n[i] = '0;
            end else if (cnt[i] == HOLD_MAX) begin
               out_n[i]   = s2[i];
               cnt_n[i]   = '0;
               press_n[i] = s2[i];
               rel_n[i]   = ~s2[i];
            end else begin
               cnt_n[i] = cnt[i] + 1'b1;
            end
         end else begin
            // The cycle right after the rise is not counted, so out stays high at least HOLDOFF+1 cycles.
            if (!out[i]) begin
               cnt_n[i] = '0;
               if (s2[i]) begin
                  out_n[i]   = 1'b1;
                  press_n[i] = 1'b1;
               end
            end else if (s2[i] || press[i]) begin
               cnt_n[i] = '0;
            end else if (cnt[i] == HOLD_MAX) begin
               out_n[i] = 1'b0;
               cnt_n[i] = '0;
               rel_n[i] = 1'b1;
            end else begin
               cnt_n[i] = cnt[i] + 1'b1;
            end
         end

         // Hold counter: idle while released, never strobes on the release edge itself.
         if (LONG_CYCLES == 0 || !out[i] || rel_n[i]) begin
            hold_n[i] = '0;
            rpt_n[i]  = 1'b0;
         end else if (!rpt[i]) begin
            if (hold[i] == LONG_MAX) begin
               long_n[i] = 1'b1;
               hold_n[i] = '0;
               rpt_n[i]  = 1'b1;
            end else begin
               hold_n[i] = hold[i] + 1'b1;
            end
         end else if (REPEAT_CYCLES > 0) begin
            if (hold[i] == REPEAT_MAX) begin
               long_n[i] = 1'b1;
               hold_n[i] = '0;
            end else begin
               hold_n[i] = hold[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         busy = busy | (cnt[i] != '0);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1             <= '0;
         s2             <= '0;
         out            <= '0;
         press          <= '0;
         release_strobe <= '0;
         long_press     <= '0;
         rpt            <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]  <= '0;
            hold[i] <= '0;
         end
      end else begin
         s1             <= pin_b;
         s2             <= s1;
         out            <= out_n;
         press          <= press_n;
         release_strobe <= rel_n;
         long_press     <= long_n;
         rpt            <= rpt_n;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]  <= cnt_n[i];
            hold[i] <= hold_n[i];
         end
      end
   end

endmodule

// File: tb/tb_button_debouncer_array.sv
// tb/tb_button_debouncer_array.sv - directed bench for button_debouncer_array
module tb_button_debouncer_array;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] sym_btn = '0, sym_out, sym_press, sym_rel, sym_long;
   logic       sym_busy;
   logic [1:0] str_btn = '0, str_out, str_press, str_rel, str_long;
   logic       str_busy;
   logic [1:0] lp_btn = '0, lp_out, lp_press, lp_rel, lp_long;
   logic       lp_busy;
   logic [1:0] al_btn = 2'b11, al_out, al_press, al_rel, al_long;
   logic       al_busy;

   button_debouncer_array #(.CHANNELS(2), .HOLDOFF(4), .CNT_W(4), .LONG_CYCLES(0),
      .REPEAT_CYCLES(0), .LONG_W(8), .ACTIVE_LOW(0), .STRETCH_MODE(0)) u_sym (
      .clock(clock), .reset(reset), .button(sym_btn), .out(sym_out), .press(sym_press),
      .release_strobe(sym_rel), .long_press(sym_long), .busy(sym_busy));

   button_debouncer_array #(.CHANNELS(2), .HOLDOFF(4), .CNT_W(4), .LONG_CYCLES(0),
      .REPEAT_CYCLES(0), .LONG_W(8), .ACTIVE_LOW(0), .STRETCH_MODE(1)) u_str (
      .clock(clock), .reset(reset), .button(str_btn), .out(str_out), .press(str_press),
      .release_strobe(str_rel), .long_press(str_long), .busy(str_busy));

   button_debouncer_array #(.CHANNELS(2), .HOLDOFF(2), .CNT_W(4), .LONG_CYCLES(10),
      .REPEAT_CYCLES(3), .LONG_W(8), .ACTIVE_LOW(0), .STRETCH_MODE(0)) u_lp (
      .clock(clock), .reset(reset), .button(lp_btn), .out(lp_out), .press(lp_press),
      .release_strobe(lp_rel), .long_press(lp_long), .busy(lp_busy));

   button_debouncer_array #(.CHANNELS(2), .HOLDOFF(4), .CNT_W(4), .LONG_CYCLES(6),
      .REPEAT_CYCLES(0), .LONG_W(8), .ACTIVE_LOW(1), .STRETCH_MODE(0)) u_al (
      .clock(clock), .reset(reset), .button(al_btn), .out(al_out), .press(al_press),
      .release_strobe(al_rel), .long_press(al_long), .busy(al_busy));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      sym_btn = 2'b11;
      al_btn  = 2'b00;
      reset   = 1'b1;
      for (int e = 0; e < 4; e++) begin
         tick();
         n_checks++;
         if ({sym_out, sym_press, sym_rel, sym_long, sym_busy} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_sym e=%0d got %b required 0", e,
                     {sym_out, sym_press, sym_rel, sym_long, sym_busy});
         end
         n_checks++;
         if ({al_out, al_press, al_rel, al_long, al_busy} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_al e=%0d got %b required 0", e,
                     {al_out, al_press, al_rel, al_long, al_busy});
         end
      end
      sym_btn = 2'b00;
      al_btn  = 2'b11;
   endtask

   // b held for len edges on ch0: {out,press,release,busy} per edge, ch1 must stay idle.
   task automatic test_pulse(input int len, input int last);
      logic [5:0] exp;
      do_reset();
      for (int e = 0; e <= last; e++) begin
         sym_btn = {1'b0, (e < len)};
         tick();
         exp[5] = (len >= 4) && (e >= 5) && (e <= len + 4);
         exp[4] = (len >= 4) && (e == 5);
         exp[3] = (len >= 4) && (len < 100) && (e == len + 5);
         exp[2] = ((e >= 2) && (e <= 4)) ||
                  ((len >= 4) && (len < 100) && (e >= len + 2) && (e <= len + 4));
         exp[1:0] = 2'b00;
         n_checks++;
         if ({sym_out[0], sym_press[0], sym_rel[0], sym_busy, sym_out[1], sym_press[1]} !== exp) begin
            n_fail++;
            $display("FAIL pulse%0d e=%0d got %b required %b", len, e,
                     {sym_out[0], sym_press[0], sym_rel[0], sym_busy, sym_out[1], sym_press[1]}, exp);
         end
      end
      sym_btn = 2'b00;
   endtask

   task automatic test_stretch();
      logic [2:0] exp;
      do_reset();
      for (int e = 0; e <= 10; e++) begin
         str_btn = {1'b0, (e < 1)};
         tick();
         exp = {(e >= 2) && (e <= 6), (e == 2), (e == 7)};
         n_checks++;
         if ({str_out[0], str_press[0], str_rel[0]} !== exp) begin
            n_fail++;
            $display("FAIL stretch e=%0d got %b required %b", e,
                     {str_out[0], str_press[0], str_rel[0]}, exp);
         end
      end
      str_btn = 2'b00;
   endtask

   task automatic test_long_press();
      logic [4:0] exp;
      do_reset();
      for (int e = 0; e <= 40; e++) begin
         lp_btn = {1'b0, (e < 30)};
         tick();
         exp = {(e >= 3) && (e <= 32), (e == 3), (e == 33),
                (e >= 13) && (e <= 31) && ((e - 13) % 3 == 0), 1'b0};
         n_checks++;
         if ({lp_out[0], lp_press[0], lp_rel[0], lp_long[0], lp_long[1]} !== exp) begin
            n_fail++;
            $display("FAIL long_press e=%0d got %b required %b", e,
                     {lp_out[0], lp_press[0], lp_rel[0], lp_long[0], lp_long[1]}, exp);
         end
      end
      lp_btn = 2'b00;
   endtask

   task automatic test_active_low();
      logic [3:0] exp;
      al_btn = 2'b10;
      do_reset();
      for (int e = 0; e <= 14; e++) begin
         tick();
         exp = {(e >= 5), (e == 5), 1'b0, (e == 11)};
         n_checks++;
         if ({al_out[0], al_press[0], al_rel[0], al_long[0]} !== exp) begin
            n_fail++;
            $display("FAIL active_low e=%0d got %b required %b", e,
                     {al_out[0], al_press[0], al_rel[0], al_long[0]}, exp);
         end
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({al_out, al_press, al_rel, al_long, al_busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL mid_hold_reset got %b required 0", {al_out, al_press, al_rel, al_long, al_busy});
      end
      al_btn = 2'b11;
      tick();
      reset = 1'b0;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if ({al_out, al_press, al_rel, al_long} !== 8'b0) begin
            n_fail++;
            $display("FAIL after_reset e=%0d got %b required 0", e, {al_out, al_press, al_rel, al_long});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp;
      do_reset();
      for (int e = 0; e <= 20; e++) begin
         sym_btn = {(e < 10), (e < 8)};
         tick();
         exp = {(e >= 5) && (e <= 14), (e >= 5) && (e <= 12),
                (e == 5), (e == 5), (e == 15), (e == 13)};
         n_checks++;
         if ({sym_out, sym_press, sym_rel} !== exp) begin
            n_fail++;
            $display("FAIL two_channel e=%0d got %b required %b", e, {sym_out, sym_press, sym_rel}, exp);
         end
      end
      sym_btn = 2'b00;
   endtask

   initial begin
      test_reset();
      test_pulse(1000, 8);
      test_pulse(3, 9);
      test_pulse(4, 12);
      test_stretch();
      test_long_press();
      test_active_low();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
